udma_adc_ts_sampler: RTL

- Upstream data source for the uDMA ADC timestamp RX channel.
- Watches NUM_CH asynchronous ADC conversion-done/event lines and tags each rising edge with the current timestamp and channel index.
- Buffers tagged words in a small FIFO and presents them as 32-bit words on the uDMA RX stream (valid/ready), gated by the channel's RX enable and clear.

---
 rtl/udma_adc_ts_sampler_if.sv | 22 ++
 rtl/udma_adc_ts_sampler.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/udma_adc_ts_sampler_if.sv
// uDMA RX stream bundle: 32-bit data word with valid/ready handshake.
// The master drives data, datasize and valid; the slave drives ready.
interface udma_adc_ts_sampler_if;
  logic [31:0] data;
  logic [1:0]  datasize;
  logic        valid;
  logic        ready;

  modport master (
    output data,
    output datasize,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  datasize,
    input  valid,
    output ready
  );
endinterface

// File: rtl/udma_adc_ts_sampler.sv
// ADC event timestamp sampler feeding the uDMA RX stream through a FIFO.
// Define ADC_TS_BOTH_EDGES_EN to also capture falling edges.
module udma_adc_ts_sampler #(
  parameter int NUM_CH     = 4,
  parameter int TS_WIDTH   = 28,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic [TS_WIDTH-1:0] ts_i,
  input  logic [NUM_CH-1:0]   ch_evt_i,
  input  logic                rx_en_i,
  input  logic                rx_clr_i,
  udma_adc_ts_sampler_if.master rx,
  output logic                ovf_o,
  output logic [NUM_CH-1:0]   pending_o
);

`ifdef ADC_TS_BOTH_EDGES_EN
  localparam int NSLOT = 2 * NUM_CH;
`else
  localparam int NSLOT = NUM_CH;
`endif
  localparam int SW = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, PUSH} state_t;

  state_t state, state_nx;

  logic [NUM_CH-1:0]   sync1, sync2, hist;
  logic [NSLOT-1:0]    edge_det, pend, pend_nx;
  logic [NSLOT-1:0]    clr_slot, load;
  logic [TS_WIDTH-1:0] cap [NSLOT];
  logic                ovf_nx;
  logic [SW-1:0]       sel;
  logic                any_pend, full;
  logic                do_push, do_pop;
  logic [3:0]          idx;
  logic [27:0]         ts_ext;
  logic [31:0]         word;
  logic [31:0]         mem [FIFO_DEPTH];
  logic [AW-1:0]       wptr, rptr;
  logic [CW-1:0]       count;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync1 <= '0;
      sync2 <= '0;
      hist  <= '0;
    end else begin
      sync1 <= ch_evt_i;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  // Slot 2c is the rising edge of channel c, 2c+1 the falling one.
  always_comb begin
    edge_det  = '0;
    pending_o = '0;
    for (int c = 0; c < NUM_CH; c++) begin
`ifdef ADC_TS_BOTH_EDGES_EN
      edge_det[2*c]   = sync2[c] & ~hist[c];
      edge_det[2*c+1] = ~sync2[c] & hist[c];
      pending_o[c]    = pend[2*c] | pend[2*c+1];
`else
      edge_det[c]  = sync2[c] & ~hist[c];
      pending_o[c] = pend[c];
`endif
    end
  end

  always_comb begin
    sel = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (pend[i]) sel = SW'(i);
    end
  end

  assign any_pend = |pend;
  assign full     = (count == CW'(FIFO_DEPTH));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    do_push  = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_pend && !full) state_nx = PUSH;
      end
      PUSH: begin
        if (any_pend && !full) do_push  = 1'b1;
        else                   state_nx = IDLE;
      end
    endcase
    if (rx_clr_i) begin
      state_nx = IDLE;
      do_push  = 1'b0;
    end
  end

  // A new edge on the slot being drained re-arms it instead of overflowing.
  always_comb begin
    clr_slot = '0;
    if (do_push) clr_slot[sel] = 1'b1;
    load    = edge_det & {NSLOT{rx_en_i & ~rx_clr_i}}
            & (~pend | clr_slot);
    pend_nx = (pend & ~clr_slot) | load;
    ovf_nx  = ovf_o
            | (|(edge_det & {NSLOT{rx_en_i}} & pend & ~clr_slot));
    if (rx_clr_i) begin
      pend_nx = '0;
      ovf_nx  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pend  <= '0;
      ovf_o <= 1'b0;
      for (int i = 0; i < NSLOT; i++) cap[i] <= '0;
    end else begin
      pend  <= pend_nx;
      ovf_o <= ovf_nx;
      for (int i = 0; i < NSLOT; i++) begin
        if (load[i]) cap[i] <= ts_i;
      end
    end
  end

  always_comb begin
    ts_ext = '0;
    ts_ext[TS_WIDTH-1:0] = cap[sel];
`ifdef ADC_TS_BOTH_EDGES_EN
    idx = {~sel[0], 3'(sel >> 1)};
`else
    idx = 4'(sel);
`endif
    word = {idx, ts_ext};
  end

  assign do_pop = rx.valid & rx.ready;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (rx_clr_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= word;
        wptr      <= wptr + AW'(1);
      end
      if (do_pop) rptr <= rptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  assign rx.valid    = (count != '0);
  assign rx.data     = mem[rptr];
  assign rx.datasize = 2'b10;

endmodule
